// File: rtl/btn_sel_pkg.sv
// btn_sel_pkg: shared constants for the button select front-end.
//   Button indices follow the btn_pulse bit order {C,U,L,R,D}.
package btn_sel_pkg;

  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned BTN_D = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_C = 4;

  // 10 ms debounce and 0.5 s scan step at 100 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_SCAN_PERIOD     = 50000000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-flop synchronizer, debounce counter,
// stable state and a registered one-cycle press pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw button pin
//   btn_db     : debounced stable state
//   btn_rise   : one-cycle pulse, the cycle after btn_db rises
module btn_debounce
  import btn_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_rise
);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic             db_prev_q;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    // any sample equal to the stable state restarts the count
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = db_q & ~db_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_db   = db_q;
  assign btn_rise = rise_q;

endmodule

// File: rtl/btn_sel_ctrl.sv
// btn_sel_ctrl: debounces the five pushbuttons and turns presses into
// registered press-to-toggle mux/demux selects.
//   btnU/btnL -> toggle mux_sel[1]/[0], btnR/btnD -> toggle demux_sel[1]/[0]
//   btnC      -> clear both selects (C wins over same-cycle toggles)
//   btn_pulse -> one-cycle debounced press pulses {C,U,L,R,D}
// Optional: BTN_SEL_AUTOSCAN_EN adds scan_active; btnC then toggles an
// autoscan that increments {mux_sel,demux_sel} every SCAN_PERIOD cycles.
module btn_sel_ctrl
  import btn_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int unsigned SCAN_PERIOD     = DEF_SCAN_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnC,
  output logic [1:0] mux_sel,
  output logic [1:0] demux_sel,
  output logic [4:0] btn_pulse
`ifdef BTN_SEL_AUTOSCAN_EN
  ,
  output logic       scan_active
`endif
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw[BTN_D] = btnD;
  assign btn_raw[BTN_R] = btnR;
  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_U] = btnU;
  assign btn_raw[BTN_C] = btnC;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .btn_db  (btn_db[i]),
      .btn_rise(btn_rise[i])
    );
  end

  logic [1:0] mux_sel_q;
  logic [1:0] mux_sel_d;
  logic [1:0] demux_sel_q;
  logic [1:0] demux_sel_d;
  logic [1:0] mux_tgl;
  logic [1:0] demux_tgl;

  assign mux_tgl   = {btn_rise[BTN_U], btn_rise[BTN_L]};
  assign demux_tgl = {btn_rise[BTN_R], btn_rise[BTN_D]};

`ifdef BTN_SEL_AUTOSCAN_EN
  localparam int unsigned SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic              scan_active_q;
  logic              scan_active_d;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [SCAN_W-1:0] scan_cnt_d;
  logic              scan_step;
  logic [3:0]        sel_cat;

  always_comb begin
    scan_active_d = scan_active_q ^ btn_rise[BTN_C];
    scan_cnt_d    = scan_cnt_q;
    scan_step     = 1'b0;
    if (btn_rise[BTN_C]) begin
      scan_cnt_d = '0;
    end else if (scan_active_q) begin
      if (scan_cnt_q == SCAN_W'(SCAN_PERIOD - 1)) begin
        scan_cnt_d = '0;
        scan_step  = 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end
    end

    // manual toggles override a scan step landing in the same cycle
    sel_cat = {mux_sel_q, demux_sel_q};
    if ((mux_tgl != 2'b00) || (demux_tgl != 2'b00)) begin
      sel_cat = {mux_sel_q ^ mux_tgl, demux_sel_q ^ demux_tgl};
    end else if (scan_step) begin
      sel_cat = sel_cat + 4'd1;
    end
    mux_sel_d   = sel_cat[3:2];
    demux_sel_d = sel_cat[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_active_q <= 1'b0;
      scan_cnt_q    <= '0;
    end else begin
      scan_active_q <= scan_active_d;
      scan_cnt_q    <= scan_cnt_d;
    end
  end

  assign scan_active = scan_active_q;
`else
  always_comb begin
    mux_sel_d   = mux_sel_q ^ mux_tgl;
    demux_sel_d = demux_sel_q ^ demux_tgl;
    if (btn_rise[BTN_C]) begin
      mux_sel_d   = '0;
      demux_sel_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel_q   <= '0;
      demux_sel_q <= '0;
    end else begin
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign demux_sel = demux_sel_q;
  assign btn_pulse = btn_rise;

endmodule
